frame_capture_writer: RTL and testbench

- Pixel-stream receiver that writes one video frame into the 640x480 RGB565 frame buffer. It is the write-side counterpart of the VGA scan-out path, which reads that buffer via a 19-bit address.
- Accepts a byte-serial camera-style stream (vsync / href / 8-bit data, two bytes per pixel) and emits word writes (address, 16-bit pixel, write strobe) to the buffer's write port.
- Sits between the camera input pins (already synchronised to clk) and the frame buffer.

---
 rtl/frame_capture_writer.sv | 195 +++++++++++++++++++
 tb/tb_frame_capture_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_writer.sv
// frame_capture_writer
// Receives a byte-serial camera stream (vsync / href / data, two bytes per
// RGB565 pixel) and turns one frame at a time into word writes for the
// H_ACT x V_ACT frame buffer. Capture is only ever armed at a vsync
// boundary, so a frame that is already in flight is never joined part-way.
// Address generation keeps a running row base (row*H_ACT) so no multiplier
// is needed: the base advances by H_ACT at every line end.

module frame_capture_writer #(
  parameter int   H_ACT     = 640,
  parameter int   V_ACT     = 480,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data,
  output logic [18:0] waddress,
  output logic [15:0] pixel_out,
  output logic        we,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun
);

  // Column counter is 11 bits so it can hold H_ACT (saturation value) for
  // any line length up to 2047. Row counter just needs to reach V_ACT.
  localparam int COL_W = 11;
  localparam int ROW_W = $clog2(V_ACT + 1);

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACT);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACT);
  localparam logic [18:0]      ROW_STEP = 19'(H_ACT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Input qualification
  logic vsync_act;
  logic vsync_act_q;
  logic href_q;
  logic href_ok;
  logic vsync_fall;

  // Frame / line / byte events
  logic frame_start;
  logic frame_end;
  logic line_end;
  logic byte_valid;

  // Position and byte assembly
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [18:0]      row_base;
  logic             phase;
  logic [7:0]       hi_byte;
  logic             in_range;

  // href is meaningless during vertical blanking, so it is masked there.
  assign vsync_act  = (vsync == VSYNC_POL);
  assign href_ok    = href & ~vsync_act;
  assign vsync_fall = vsync_act_q & ~vsync_act;

  assign frame_start = (state == WAIT_START) & vsync_fall;
  assign frame_end   = (state == CAPTURE) & vsync_act;
  assign byte_valid  = (state == CAPTURE) & href_ok;
  // href_q only ever goes high while capturing, so a falling edge here is
  // always a genuine end of a captured line.
  assign line_end    = (state == CAPTURE) & href_q & ~href_ok;

  assign in_range = (row < ROW_MAX) && (col < COL_MAX);

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: arm on an active vsync, start on its trailing edge,
  // finish on the next active vsync and re-arm only if still enabled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable && vsync_act) begin
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (vsync_fall) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vsync_act) begin
          state_next = enable ? WAIT_START : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Delayed copies of qualified vsync/href for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_act_q <= 1'b0;
      href_q      <= 1'b0;
    end else begin
      vsync_act_q <= vsync_act;
      href_q      <= byte_valid;
    end
  end

  // Row / column / byte-phase tracking; line end discards an odd byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      phase    <= 1'b0;
      hi_byte  <= '0;
    end else if (frame_start) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      phase    <= 1'b0;
    end else if (byte_valid) begin
      if (!phase) begin
        hi_byte <= data;
        phase   <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (col < COL_MAX) begin
          col <= col + COL_W'(1);
        end
      end
    end else if (line_end) begin
      col   <= '0;
      phase <= 1'b0;
      if (row < ROW_MAX) begin
        row      <= row + ROW_W'(1);
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  // Write port: one-cycle strobe after the second byte of an in-range pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we        <= 1'b0;
      waddress  <= '0;
      pixel_out <= '0;
    end else begin
      we <= 1'b0;
      if (byte_valid && phase && in_range) begin
        we        <= 1'b1;
        waddress  <= row_base + 19'(col);
        pixel_out <= {hi_byte, data};
      end
    end
  end

  // Status: frame_done pulse and sticky overrun. Overrun is flagged as soon
  // as the first byte of an out-of-range pixel arrives, so a lone trailing
  // byte past the last column still counts as excess data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_start) begin
        overrun <= 1'b0;
      end else if (byte_valid && !in_range) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Bench for frame_capture_writer with a reduced 4x2 frame. A byte-level
// model of the stream pushes expected writes (address, pixel, cycle) into a
// queue while stimulus is driven; a negedge monitor pops and compares each
// write strobe the DUT produces.

module tb_frame_capture_writer;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic [18:0] waddress;
  logic [15:0] pixel_out;
  logic        we;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  frame_capture_writer #(
    .H_ACT(H),
    .V_ACT(V),
    .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .vsync(vsync),
    .href(href),
    .data(data),
    .waddress(waddress),
    .pixel_out(pixel_out),
    .we(we),
    .frame_done(frame_done),
    .busy(busy),
    .overrun(overrun)
  );

  typedef struct {
    logic [18:0] addr;
    logic [15:0] pix;
    int          cyc;
  } wr_t;

  wr_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_count = 0;
  int exp_fd = 0;

  // Stream model state
  int         m_row = 0;
  int         m_col = 0;
  int         m_phase = 0;
  logic [7:0] m_hi = 8'h00;
  bit         m_cap = 1'b0;
  bit         m_ovr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor and frame_done counter
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (we) begin
      check("we_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        wr_t e;
        e = q.pop_front();
        $display("write addr=%0d pix=%04h cyc=%0d (exp addr=%0d pix=%04h cyc=%0d)",
                 waddress, pixel_out, cyc, e.addr, e.pix, e.cyc);
        check("waddress", 32'(waddress), 32'(e.addr));
        check("pixel_out", 32'(pixel_out), 32'(e.pix));
        check("we_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d);
    href = 1'b1;
    data = d;
    if (m_cap) begin
      if (m_phase == 0) begin
        m_hi    = d;
        m_phase = 1;
        if (!(m_row < V && m_col < H)) m_ovr = 1'b1;
      end else begin
        m_phase = 0;
        if (m_row < V && m_col < H) begin
          wr_t e;
          e.addr = 19'(m_row * H + m_col);
          e.pix  = {m_hi, d};
          e.cyc  = cyc + 1;
          q.push_back(e);
        end else begin
          m_ovr = 1'b1;
        end
        if (m_col < H) m_col++;
      end
    end
    tick();
  endtask

  task automatic end_line();
    href = 1'b0;
    data = 8'h00;
    if (m_cap) begin
      m_col   = 0;
      m_phase = 0;
      if (m_row < V) m_row++;
    end
    repeat (3) tick();
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      drive_byte(b);
    end
    end_line();
  endtask

  task automatic vsync_pulse();
    if (m_cap) exp_fd++;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    m_cap = enable;
    if (m_cap) begin
      m_row   = 0;
      m_col   = 0;
      m_phase = 0;
      m_ovr   = 1'b0;
    end
    repeat (3) tick();
    check("frame_done_count", 32'(fd_count), 32'(exp_fd));
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    vsync   = 1'b0;
    href    = 1'b0;
    data    = 8'h00;

    // Reset held while the stream and a vsync pulse keep running
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      href = 1'b1;
      data = 8'(8'hA0 + i);
      tick();
    end
    href = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddress", 32'(waddress), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Release with enable low: a whole frame passes with no writes
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    vsync_pulse();
    send_line(8, 8'h50);
    send_line(8, 8'h60);
    vsync_pulse();
    check("disabled_busy", 32'(busy), 32'd0);

    // Small frame: 2 lines x 8 bytes 0x00..0x0F -> addr 0..7
    enable = 1'b1;
    vsync_pulse();
    check("armed_busy", 32'(busy), 32'd1);
    send_line(8, 8'h00);
    send_line(8, 8'h08);
    check("small_overrun", 32'(overrun), 32'(m_ovr));
    vsync_pulse();
    check("small_q_empty", 32'(q.size()), 32'd0);

    // 9-byte line: 4 writes, overrun set; next line starts at addr 4
    send_line(9, 8'h10);
    check("col_cap_overrun", 32'(overrun), 32'(m_ovr));
    send_line(8, 8'h20);
    check("col_cap_overrun_sticky", 32'(overrun), 32'(m_ovr));
    vsync_pulse();
    check("overrun_cleared", 32'(overrun), 32'(m_ovr));

    // Short line of 2 pixels then a full line: addr 0,1 then 4..7
    send_line(4, 8'h30);
    send_line(8, 8'h38);
    check("short_overrun", 32'(overrun), 32'(m_ovr));
    // A third line lies past V_ACT: no writes, overrun set
    send_line(4, 8'h48);
    check("row_cap_overrun", 32'(overrun), 32'(m_ovr));

    // Late enable: disable, let the frame end, enable mid-frame
    enable = 1'b0;
    vsync_pulse();
    check("late_idle_busy", 32'(busy), 32'd0);
    send_line(8, 8'h70);
    enable = 1'b1;
    send_line(8, 8'h78);
    check("late_still_idle", 32'(busy), 32'd0);
    vsync_pulse();
    send_line(8, 8'h80);
    send_line(8, 8'h88);
    vsync_pulse();

    // Reset during line 1 with a write just issued
    send_line(8, 8'h90);
    drive_byte(8'hC0);
    drive_byte(8'hC1);
    reset_n = 1'b0;
    #1;
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_waddress", 32'(waddress), 32'd0);
    q.delete();
    m_cap = 1'b0;
    m_ovr = 1'b0;
    href  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    // No vsync yet: stream must be ignored
    send_line(8, 8'hD0);
    check("postrst_idle", 32'(busy), 32'd0);
    vsync_pulse();
    send_line(8, 8'hE0);
    send_line(8, 8'hE8);
    vsync_pulse();

    repeat (4) tick();
    check("final_q_empty", 32'(q.size()), 32'd0);
    check("final_frame_done_count", 32'(fd_count), 32'(exp_fd));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
